// File: rtl/uart_pkg.sv
// Shared constants, timing helpers and RX state encoding for the UART receive path.
package uart_pkg;

  // Bytes per bulk-write frame: one address byte followed by four data bytes.
  localparam int unsigned FRAME_BYTES = 5;

  // Default RAM address width for a 256-word RAM.
  localparam int unsigned ADDR_W = 8;

  // Clock cycles per serial bit.
  function automatic int unsigned calc_bit_cyc(input int unsigned clk_freq,
                                               input int unsigned baud);
    return clk_freq / baud;
  endfunction

  // Clock cycles from the start-bit edge to the start-bit centre.
  function automatic int unsigned calc_half_cyc(input int unsigned clk_freq,
                                                input int unsigned baud);
    return (clk_freq / baud) / 2;
  endfunction

  // RX FSM state encoding.
  typedef logic [1:0] rx_state_t;
  localparam rx_state_t RX_IDLE  = 2'd0;
  localparam rx_state_t RX_START = 2'd1;
  localparam rx_state_t RX_DATA  = 2'd2;
  localparam rx_state_t RX_STOP  = 2'd3;

endpackage

// File: rtl/uart_rx_controller_if.sv
// Bulk write bus: a valid/ready request carrying one RAM address and one data word.
interface uart_rx_controller_if #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DATA_W = 32
) ();

  logic              bulk_rx_valid;
  logic              bulk_rx_ready;
  logic [ADDR_W-1:0] bulk_rx_addr;
  logic [DATA_W-1:0] bulk_rx_data;

  modport master (
    output bulk_rx_valid,
    output bulk_rx_addr,
    output bulk_rx_data,
    input  bulk_rx_ready
  );

  modport slave (
    input  bulk_rx_valid,
    input  bulk_rx_addr,
    input  bulk_rx_data,
    output bulk_rx_ready
  );

endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: synchronizes the serial line, samples each bit at its centre and
// emits the received byte with a one-cycle strobe.
module uart_rx_byte
  import uart_pkg::*;
#(
  parameter int unsigned BIT_CYC  = 868,
  parameter int unsigned HALF_CYC = 434
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rxd_i,
  output logic [7:0] byte_o,
  output logic       strobe_o
);

  localparam int unsigned CntW = $clog2(BIT_CYC + 1);

  logic            rxd_meta_q;
  logic            rxd_sync_q;
  logic            rxd_prev_q;
  logic            fall;
  rx_state_t       state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      bit_q, bit_d;
  logic [7:0]      shift_q, shift_d;
  logic            strobe_q, strobe_d;

  // Two-flop synchronizer plus one delayed copy for edge detection; idles high.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rxd_meta_q <= 1'b1;
      rxd_sync_q <= 1'b1;
      rxd_prev_q <= 1'b1;
    end else begin
      rxd_meta_q <= rxd_i;
      rxd_sync_q <= rxd_meta_q;
      rxd_prev_q <= rxd_sync_q;
    end
  end

  assign fall = rxd_prev_q & ~rxd_sync_q;

  // Next-state logic: start-bit qualification, LSB-first data sampling, stop-bit wait.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    strobe_d = 1'b0;
    case (state_q)
      RX_IDLE: begin
        cnt_d = '0;
        if (fall) begin
          state_d = RX_START;
        end
      end
      RX_START: begin
        if (cnt_q == CntW'(HALF_CYC - 1)) begin
          cnt_d   = '0;
          bit_d   = '0;
          // A line already back high at the start-bit centre was a glitch.
          state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_DATA: begin
        if (cnt_q == CntW'(BIT_CYC - 1)) begin
          cnt_d   = '0;
          shift_d = {rxd_sync_q, shift_q[7:1]};
          bit_d   = bit_q + 1'b1;
          if (bit_q == 3'd7) begin
            state_d = RX_STOP;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      RX_STOP: begin
        // Stop-bit level is ignored; the byte is delivered regardless.
        if (cnt_q == CntW'(BIT_CYC - 1)) begin
          cnt_d    = '0;
          strobe_d = 1'b1;
          state_d  = RX_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: begin
        state_d = RX_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // FSM state registers; reset discards any partially received byte.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RX_IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      strobe_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      strobe_q <= strobe_d;
    end
  end

  assign byte_o   = shift_q;
  assign strobe_o = strobe_q;

endmodule

// File: rtl/uart_rx_controller.sv
// UART frame receiver: bytes from uart_rx_byte are buffered in a FIFO and assembled
// into {address, 32-bit data} bulk writes, MSB first.
module uart_rx_controller
  import uart_pkg::*;
#(
  parameter int unsigned UART_FIFO_DEPTH = 64,
  parameter int unsigned UART_BAUD_RATE  = 115200,
  parameter int unsigned CLK_FREQ        = 100_000_000,
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned RAM_DEPTH       = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    uart_rxd,
  uart_rx_controller_if.master    w_bus
);

  localparam int unsigned BitCyc  = calc_bit_cyc(CLK_FREQ, UART_BAUD_RATE);
  localparam int unsigned HalfCyc = calc_half_cyc(CLK_FREQ, UART_BAUD_RATE);
  localparam int unsigned AddrW   = $clog2(RAM_DEPTH);
  localparam int unsigned PtrW    = $clog2(UART_FIFO_DEPTH);

  logic [7:0] rx_byte;
  logic       rx_strobe;

  uart_rx_byte #(
    .BIT_CYC  (BitCyc),
    .HALF_CYC (HalfCyc)
  ) u_rx (
    .clk      (clk),
    .rst      (rst),
    .rxd_i    (uart_rxd),
    .byte_o   (rx_byte),
    .strobe_o (rx_strobe)
  );

  // Byte FIFO; pointers carry an extra wrap bit to tell full from empty.
  logic [7:0]  mem [UART_FIFO_DEPTH];
  logic [PtrW:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW:0] rd_ptr_q, rd_ptr_d;
  logic        fifo_empty;
  logic        fifo_full;
  logic        push;
  logic        pop;
  logic [7:0]  rd_byte;

  logic [AddrW-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  valid_q, valid_d;
  logic [2:0]            cnt_q, cnt_d;

  // FIFO status, push/pop qualification and pointer advance.
  always_comb begin
    fifo_empty = (wr_ptr_q == rd_ptr_q);
    fifo_full  = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
                 (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    // A byte arriving while full is dropped even if a pop happens in the same cycle.
    push       = rx_strobe & ~fifo_full;
    pop        = ~fifo_empty & ~valid_q;
    wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    rd_byte    = mem[rd_ptr_q[PtrW-1:0]];
  end

  // FIFO storage; contents need no reset since the pointers define validity.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_q[PtrW-1:0]] <= rx_byte;
    end
  end

  // FIFO pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Frame assembler: byte 0 is the address, bytes 1..4 shift into data MSB first.
  always_comb begin
    addr_d  = addr_q;
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (valid_q && w_bus.bulk_rx_ready) begin
      valid_d = 1'b0;
    end
    if (pop) begin
      if (cnt_q == 3'd0) begin
        addr_d = AddrW'(rd_byte);
      end else begin
        data_d = {data_q[DATA_WIDTH-9:0], rd_byte};
      end
      if (cnt_q == 3'(FRAME_BYTES - 1)) begin
        valid_d = 1'b1;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Assembler and bus output registers; reset drops any partial frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q  <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      addr_q  <= addr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  assign w_bus.bulk_rx_valid = valid_q;
  assign w_bus.bulk_rx_addr  = addr_q;
  assign w_bus.bulk_rx_data  = data_q;

endmodule

// File: tb/tb_uart_rx_controller.sv
// Directed bench for uart_rx_controller at 16 clocks per bit.
module tb_uart_rx_controller;
  import uart_pkg::*;

  localparam int unsigned ClkFreq = 1_843_200;
  localparam int unsigned Baud    = 115200;
  localparam int unsigned BitC    = 16;
  localparam int unsigned Depth   = 64;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic rxd = 1'b1;

  always #5 clk = ~clk;

  uart_rx_controller_if #(.ADDR_W(8), .DATA_W(32)) bus ();

  uart_rx_controller #(
    .UART_FIFO_DEPTH (Depth),
    .UART_BAUD_RATE  (Baud),
    .CLK_FREQ        (ClkFreq),
    .DATA_WIDTH      (32),
    .RAM_DEPTH       (256)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .uart_rxd (rxd),
    .w_bus    (bus)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  logic [7:0]  got_a [$];
  logic [31:0] got_d [$];
  int          got_w [$];
  int          got_t [$];
  int          vwidth = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Records every accepted write, its valid-high width and its cycle stamp.
  always @(negedge clk) begin
    if (rst) begin
      vwidth = 0;
    end else if (bus.bulk_rx_valid) begin
      vwidth++;
      if (bus.bulk_rx_ready) begin
        got_a.push_back(bus.bulk_rx_addr);
        got_d.push_back(bus.bulk_rx_data);
        got_w.push_back(vwidth);
        got_t.push_back(cyc);
        vwidth = 0;
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_q();
    got_a.delete();
    got_d.delete();
    got_w.delete();
    got_t.delete();
  endtask

  task automatic set_ready(input logic r);
    @(posedge clk);
    #1 bus.bulk_rx_ready = r;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rxd = 1'b0;
    idle(BitC);
    for (int i = 0; i < 8; i++) begin
      rxd = b[i];
      idle(BitC);
    end
    rxd = stop_bit;
    idle(BitC);
    rxd = 1'b1;
    if (!stop_bit) idle(BitC);
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [31:0] d);
    send_byte(a, 1'b1);
    for (int i = 3; i >= 0; i--) send_byte(d[8*i+:8], 1'b1);
  endtask

  task automatic wait_count(input int n, input int budget);
    int k;
    k = 0;
    while (got_a.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic check_out_reset(input string tag);
    check({tag, "_valid"}, 32'(bus.bulk_rx_valid), 32'h0);
    check({tag, "_addr"},  32'(bus.bulk_rx_addr),  32'h0);
    check({tag, "_data"},  bus.bulk_rx_data,       32'h0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    bus.bulk_rx_ready = 1'b0;
    rst = 1'b1;
    idle(4);
    check_out_reset("t1_rst");
    check("t1_rst_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    rst = 1'b0;
    idle(4);

    // 1: frame held with ready low, then accepted.
    send_frame(8'h32, 32'h0123_4567);
    idle(BitC);
    check("t1_valid", 32'(bus.bulk_rx_valid), 32'h1);
    check("t1_addr",  32'(bus.bulk_rx_addr),  32'h32);
    check("t1_data",  bus.bulk_rx_data,       32'h0123_4567);
    idle(20);
    check("t1_hold_addr", 32'(bus.bulk_rx_addr), 32'h32);
    check("t1_hold_data", bus.bulk_rx_data,      32'h0123_4567);
    set_ready(1'b1);
    @(negedge clk);
    check("t1_acc_valid", 32'(bus.bulk_rx_valid), 32'h1);
    check("t1_acc_data",  bus.bulk_rx_data,       32'h0123_4567);
    @(negedge clk);
    check("t1_drop_valid", 32'(bus.bulk_rx_valid), 32'h0);
    check("t1_count", 32'(got_a.size()), 32'd1);
    if (got_a.size() >= 1) check("t1_got_addr", 32'(got_a[0]), 32'h32);

    // 2: back-to-back frames with ready held high.
    clear_q();
    send_frame(8'h10, 32'hAABB_CCDD);
    send_frame(8'h11, 32'h1122_3344);
    wait_count(2, 200);
    check("t2_count", 32'(got_a.size()), 32'd2);
    if (got_a.size() >= 2) begin
      check("t2_a0", 32'(got_a[0]), 32'h10);
      check("t2_d0", got_d[0], 32'hAABB_CCDD);
      check("t2_w0", 32'(got_w[0]), 32'd1);
      check("t2_a1", 32'(got_a[1]), 32'h11);
      check("t2_d1", got_d[1], 32'h1122_3344);
      check("t2_w1", 32'(got_w[1]), 32'd1);
    end

    // 3: short start glitch is rejected.
    clear_q();
    rxd = 1'b0;
    idle(4);
    rxd = 1'b1;
    idle(3 * BitC);
    check("t3_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    check("t3_no_write", 32'(got_a.size()), 32'd0);
    send_frame(8'h77, 32'hCAFE_F00D);
    wait_count(1, 200);
    check("t3_count", 32'(got_a.size()), 32'd1);
    if (got_a.size() >= 1) begin
      check("t3_addr", 32'(got_a[0]), 32'h77);
      check("t3_data", got_d[0], 32'hCAFE_F00D);
    end

    // 4: 15 frames while stalled; one frame held + 64 FIFO bytes survive, 6 dropped.
    clear_q();
    set_ready(1'b0);
    for (int f = 0; f < 15; f++) send_frame(8'(8'h80 + f), 32'h0101_0101 * 32'(f + 1));
    idle(BitC);
    check("t4_stall_valid", 32'(bus.bulk_rx_valid), 32'h1);
    check("t4_stall_addr",  32'(bus.bulk_rx_addr),  32'h80);
    set_ready(1'b1);
    wait_count(13, 2000);
    idle(50);
    check("t4_count", 32'(got_a.size()), 32'd13);
    if (got_a.size() >= 13) begin
      for (int i = 0; i < 13; i++) begin
        check($sformatf("t4_a%0d", i), 32'(got_a[i]), 32'(8'h80 + i));
        check($sformatf("t4_d%0d", i), got_d[i], 32'h0101_0101 * 32'(i + 1));
      end
      check("t4_gap", 32'(got_t[2] - got_t[1]), 32'd6);
    end

    // 5: reset in the middle of a frame and in the middle of a byte.
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(3);
    clear_q();
    send_byte(8'h5A, 1'b1);
    send_byte(8'h01, 1'b1);
    rxd = 1'b0;
    idle(2 * BitC);
    rxd = 1'b1;
    rst = 1'b1;
    idle(3);
    check_out_reset("t5_rst");
    check("t5_rst_state", 32'(dut.u_rx.state_q), 32'(RX_IDLE));
    rst = 1'b0;
    idle(2 * BitC);
    send_frame(8'hC3, 32'h89AB_CDEF);
    wait_count(1, 200);
    idle(50);
    check("t5_count", 32'(got_a.size()), 32'd1);
    if (got_a.size() >= 1) begin
      check("t5_addr", 32'(got_a[0]), 32'hC3);
      check("t5_data", got_d[0], 32'h89AB_CDEF);
    end

    // 6: a low stop bit still delivers the byte.
    clear_q();
    send_byte(8'h40, 1'b1);
    send_byte(8'hDE, 1'b0);
    send_byte(8'hAD, 1'b1);
    send_byte(8'hBE, 1'b1);
    send_byte(8'hEF, 1'b1);
    wait_count(1, 200);
    check("t6_count", 32'(got_a.size()), 32'd1);
    if (got_a.size() >= 1) begin
      check("t6_addr", 32'(got_a[0]), 32'h40);
      check("t6_data", got_d[0], 32'hDEAD_BEEF);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
